// File: rtl/wimax_interleaver_top.sv
`default_nettype none
// ============================================================================
// Module   : wimax_interleaver_top
// Brief    : Bit-serial 802.16 OFDM block interleaver with a ping-pong buffer
// Revision : 1.0
// ============================================================================
module wimax_interleaver_top #(
    parameter int NCBPS = 192,
    parameter int NCPC  = 2,
    parameter int S     = ((NCPC / 2) > 1) ? (NCPC / 2) : 1,
    parameter int D     = 16,
    localparam int W    = $clog2(NCBPS)
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         data_in,
    input  logic         valid_in,
    input  logic         ready_in,
    output logic         data_out,
    output logic         valid_out,
    output logic         ready_out,
    output logic [W-1:0] data_out_index
);

    localparam logic [31:0] C_N    = 32'(NCBPS);
    localparam logic [31:0] C_D    = 32'(D);
    localparam logic [31:0] C_S    = 32'(S);
    localparam logic [31:0] C_ROWS = 32'(NCBPS / D);
    localparam logic [W-1:0] C_LAST = W'(NCBPS - 1);

    logic             wr_bank;
    logic             rd_bank;
    logic [W-1:0]     wr_cnt;
    logic [W-1:0]     rd_ptr;
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic [NCBPS-1:0] mem [2];

    logic             wr_fire;
    logic             rd_fire;
    logic             wr_last;
    logic             rd_last;
    logic [31:0]      perm_k;
    logic [31:0]      perm_m;
    logic [31:0]      perm_j;
    logic [W-1:0]     wr_addr;

    assign ready_out      = !full[wr_bank] && !resetN;
    assign valid_out      = full[rd_bank] && !resetN;
    assign data_out       = mem[rd_bank][rd_ptr];
    assign data_out_index = rd_ptr;

    assign wr_fire = valid_in && ready_out;
    assign rd_fire = valid_out && ready_in;
    assign wr_last = (wr_cnt == C_LAST);
    assign rd_last = (rd_ptr == C_LAST);

    // Two-step permutation: column-major spread, then the intra-carrier rotation.
    always_comb begin
        perm_k  = 32'(wr_cnt);
        perm_m  = C_ROWS * (perm_k % C_D) + (perm_k / C_D);
        perm_j  = C_S * (perm_m / C_S)
                + ((perm_m + C_N - ((C_D * perm_m) / C_N)) % C_S);
        wr_addr = perm_j[W-1:0];
    end

    // Write and read completions can never target the same bank in one cycle.
    always_comb begin
        full_nxt = full;
        if (wr_fire && wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_fire && rd_last) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_ptr  <= '0;
            full    <= 2'b00;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt  <= wr_cnt + W'(1);
                end
            end
            if (rd_fire) begin
                if (rd_last) begin
                    rd_ptr  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_ptr  <= rd_ptr + W'(1);
                end
            end
        end
    end

    // Payload storage carries no reset; the full flags qualify its contents.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_addr] <= data_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wimax_interleaver_top.sv
`default_nettype none
// Scoreboard bench for wimax_interleaver_top: expected output bits are queued
// per block at stimulus time and checked by an independent output monitor.
module tb_wimax_interleaver_top;

    localparam logic [191:0] GOLD_IN  = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;
    localparam logic [191:0] GOLD_OUT = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;

    typedef struct {
        logic [7:0] idx;
        logic       bitv;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetN;
    logic       data_in;
    logic       valid_in;
    logic       ready_in;
    logic       data_out;
    logic       valid_out;
    logic       ready_out;
    logic [7:0] data_out_index;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   stall_cnt  = 0;
    int   rdy_mode   = 0;

    wimax_interleaver_top dut (
        .clk            (clk),
        .resetN         (resetN),
        .data_in        (data_in),
        .valid_in       (valid_in),
        .ready_in       (ready_in),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .ready_out      (ready_out),
        .data_out_index (data_out_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_block(input logic [191:0] vec);
        for (int i = 0; i < 192; i++) begin
            exp_t e;
            e.idx  = 8'(i);
            e.bitv = vec[i];
            q.push_back(e);
        end
    endtask

    task automatic send_bits(input logic [191:0] vec, input int nbits, input bit gaps);
        for (int i = 0; i < nbits; i++) begin
            bit acc;
            int tmo;
            if (gaps) begin
                valid_in = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            valid_in = 1'b1;
            data_in  = vec[i];
            tmo      = 0;
            do begin
                @(negedge clk);
                acc = ready_out;
                @(posedge clk); #1;
                if (!acc) begin
                    stall_cnt++;
                    tmo++;
                end
                if (tmo > 3000) begin
                    check("send_timeout", 32'(tmo), 32'd0);
                    valid_in = 1'b0;
                    return;
                end
            end while (!acc);
        end
        valid_in = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_complete", 32'(q.size()), 32'd0);
    endtask

    task automatic set_ready_mode(input int mode);
        rdy_mode = mode;
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    // Downstream readiness pattern, updated just after each active edge.
    initial begin
        ready_in = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       ready_in = 1'b1;
                1:       ready_in = ($urandom_range(0, 3) != 0);
                default: ready_in = 1'b0;
            endcase
        end
    end

    // Output monitor: compares every transfer, and the held value while stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (valid_out) begin
                if (q.size() == 0) begin
                    if (ready_in) begin
                        check("unexpected_output", 32'd1, 32'd0);
                    end
                end else begin
                    check(ready_in ? "out_index" : "stall_index", 32'(data_out_index), 32'(q[0].idx));
                    check(ready_in ? "out_bit" : "stall_bit", 32'(data_out), 32'(q[0].bitv));
                    if (ready_in) begin
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wk  [4] = '{17, 0, 191, 15};
        int wpos[4] = '{13, 0, 191, 180};
        logic [191:0] vin;
        logic [191:0] vout;

        resetN   = 1'b1;
        data_in  = 1'b0;
        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid_out", 32'(valid_out), 32'd0);
        check("reset_ready_out", 32'(ready_out), 32'd0);
        check("reset_index", 32'(data_out_index), 32'd0);
        @(posedge clk); #1;
        resetN = 1'b0;
        @(negedge clk);
        check("post_reset_ready_out", 32'(ready_out), 32'd1);
        check("post_reset_valid_out", 32'(valid_out), 32'd0);
        @(posedge clk); #1;

        // Single golden block
        push_block(GOLD_OUT);
        send_bits(GOLD_IN, 192, 1'b0);
        wait_drain();

        // Walking-one positions
        for (int n = 0; n < 4; n++) begin
            vin  = '0;
            vout = '0;
            vin[wk[n]]    = 1'b1;
            vout[wpos[n]] = 1'b1;
            push_block(vout);
            send_bits(vin, 192, 1'b0);
        end
        wait_drain();

        // Back-to-back streaming must never stall the writer
        stall_cnt = 0;
        for (int b = 0; b < 10; b++) begin
            push_block(GOLD_OUT);
            send_bits(GOLD_IN, 192, 1'b0);
        end
        check("stream_ready_stalls", 32'(stall_cnt), 32'd0);
        wait_drain();

        // Backpressure: both banks fill, then drain in order
        set_ready_mode(2);
        push_block(GOLD_OUT);
        send_bits(GOLD_IN, 192, 1'b0);
        vin  = '0;
        vout = '0;
        vin[17]  = 1'b1;
        vout[13] = 1'b1;
        push_block(vout);
        send_bits(vin, 192, 1'b0);
        @(negedge clk);
        check("both_full_ready_out", 32'(ready_out), 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("held_ready_out", 32'(ready_out), 32'd0);
        check("held_valid_out", 32'(valid_out), 32'd1);
        @(posedge clk); #1;
        set_ready_mode(0);
        wait_drain();

        // Reset mid-operation discards a full bank and a partial one
        set_ready_mode(2);
        send_bits(GOLD_IN, 192, 1'b0);
        send_bits(GOLD_IN, 100, 1'b0);
        @(negedge clk);
        check("pre_reset_valid_out", 32'(valid_out), 32'd1);
        @(posedge clk); #1;
        resetN = 1'b1;
        q.delete();
        @(negedge clk);
        check("midreset_valid_out", 32'(valid_out), 32'd0);
        check("midreset_ready_out", 32'(ready_out), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("midreset_valid_out_2", 32'(valid_out), 32'd0);
        check("midreset_index", 32'(data_out_index), 32'd0);
        @(posedge clk); #1;
        resetN = 1'b0;
        set_ready_mode(0);
        push_block(GOLD_OUT);
        send_bits(GOLD_IN, 192, 1'b0);
        wait_drain();

        // Random gaps on both sides
        set_ready_mode(1);
        for (int b = 0; b < 2; b++) begin
            push_block(GOLD_OUT);
            send_bits(GOLD_IN, 192, 1'b1);
        end
        set_ready_mode(0);
        wait_drain();
        repeat (4) @(posedge clk);
        #1;
        check("final_queue_empty", 32'(q.size()), 32'd0);
        @(negedge clk);
        check("final_valid_out", 32'(valid_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
